// File: rtl/mult_hilo_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : mult_hilo_ctrl_pkg
// Brief    : Shared CPU constants for the HI/LO multiply controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mult_hilo_ctrl_pkg;

  localparam int HILO_W = 32;
  localparam int OP_W   = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Two's-complement magnitude; 16'h8000 maps to itself, read back as unsigned.
  function automatic logic [OP_W-1:0] op_mag(input logic [OP_W-1:0] v, input logic sgn);
    return (sgn && v[OP_W-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_hilo_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : mult_hilo_ctrl_if
// Brief    : Pipeline and multiplier signal bundle for mult_hilo_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mult_hilo_ctrl_if;
  import mult_hilo_ctrl_pkg::*;

  logic              req;
  logic              sgn;
  logic [OP_W-1:0]   opa;
  logic [OP_W-1:0]   opb;
  logic              rdhi;
  logic              rdlo;
  logic              wrhi;
  logic              wrlo;
  logic [HILO_W-1:0] wrdata;
  logic [HILO_W-1:0] rddata;
  logic              busy;
  logic              stall;
  logic [OP_W-1:0]   mula;
  logic [OP_W-1:0]   mulb;
  logic              mulst;
  logic [HILO_W-1:0] mulr;
  logic              muldone;
  logic              mulidle;

  modport master (
    output req, sgn, opa, opb, rdhi, rdlo, wrhi, wrlo, wrdata,
    output mulr, muldone, mulidle,
    input  rddata, busy, stall, mula, mulb, mulst
  );

  modport slave (
    input  req, sgn, opa, opb, rdhi, rdlo, wrhi, wrlo, wrdata,
    input  mulr, muldone, mulidle,
    output rddata, busy, stall, mula, mulb, mulst
  );

endinterface

`default_nettype wire

// File: rtl/mult_hilo_ctrl_hilo_regs.sv
//------------------------------------------------------------------------------
// Module   : hilo_regs
// Brief    : HI/LO register pair with independent write enables and read mux.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hilo_regs
  import mult_hilo_ctrl_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_hi_we,
  input  wire logic [HILO_W-1:0] i_hi_d,
  input  wire logic              i_lo_we,
  input  wire logic [HILO_W-1:0] i_lo_d,
  input  wire logic              i_rdhi,
  input  wire logic              i_rdlo,
  output      logic [HILO_W-1:0] o_rddata
);

  logic [HILO_W-1:0] r_hi;
  logic [HILO_W-1:0] r_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (i_hi_we) r_hi <= i_hi_d;
      if (i_lo_we) r_lo <= i_lo_d;
    end
  end

  // HI wins when both reads are requested.
  always_comb begin
    o_rddata = '0;
    if (i_rdhi)      o_rddata = r_hi;
    else if (i_rdlo) o_rddata = r_lo;
  end

endmodule

`default_nettype wire

// File: rtl/mult_hilo_ctrl.sv
//------------------------------------------------------------------------------
// Module   : mult_hilo_ctrl
// Brief    : Sequences MULT/MULTU through an external shift-add multiplier.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult_hilo_ctrl
  import mult_hilo_ctrl_pkg::*;
(
  input wire logic       clk,
  input wire logic       rst_n,
  mult_hilo_ctrl_if.slave bus
);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [OP_W-1:0]   r_mula;
  logic [OP_W-1:0]   r_mulb;
  logic              r_sgn;
  logic              r_neg;
  logic              w_idle;
  logic              w_done;
  logic              w_hi_we;
  logic              w_lo_we;
  logic [HILO_W-1:0] w_hi_d;
  logic [HILO_W-1:0] w_lo_d;
  logic [HILO_W-1:0] w_lo_prod;
  logic [HILO_W-1:0] w_hi_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (bus.req)     w_next_state = ST_START;
      ST_START: if (bus.mulidle) w_next_state = ST_WAIT;
      ST_WAIT:  if (bus.muldone) w_next_state = ST_IDLE;
      default:                   w_next_state = ST_IDLE;
    endcase
  end

  // Operands only load from IDLE, so they stay put for the whole operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mula <= '0;
      r_mulb <= '0;
      r_sgn  <= 1'b0;
      r_neg  <= 1'b0;
    end else if (r_state == ST_IDLE && bus.req) begin
      r_mula <= op_mag(bus.opa, bus.sgn);
      r_mulb <= op_mag(bus.opb, bus.sgn);
      r_sgn  <= bus.sgn;
      r_neg  <= bus.sgn & (bus.opa[OP_W-1] ^ bus.opb[OP_W-1]);
    end
  end

  assign w_lo_prod = r_neg ? (~bus.mulr + 32'd1) : bus.mulr;
  assign w_hi_prod = (r_sgn && w_lo_prod[HILO_W-1]) ? {HILO_W{1'b1}} : '0;

  always_comb begin
    w_idle    = (r_state == ST_IDLE);
    w_done    = (r_state == ST_WAIT) && bus.muldone;
    bus.busy  = !w_idle;
    bus.mulst = (r_state == ST_START) && bus.mulidle;
    bus.stall = !w_idle && (bus.req || bus.rdhi || bus.rdlo || bus.wrhi || bus.wrlo);
    w_hi_we   = w_done || (w_idle && bus.wrhi);
    w_lo_we   = w_done || (w_idle && bus.wrlo);
    w_hi_d    = w_done ? w_hi_prod : bus.wrdata;
    w_lo_d    = w_done ? w_lo_prod : bus.wrdata;
  end

  assign bus.mula = r_mula;
  assign bus.mulb = r_mulb;

  hilo_regs u_hilo_regs (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_hi_we  (w_hi_we),
    .i_hi_d   (w_hi_d),
    .i_lo_we  (w_lo_we),
    .i_lo_d   (w_lo_d),
    .i_rdhi   (bus.rdhi),
    .i_rdlo   (bus.rdlo),
    .o_rddata (bus.rddata)
  );

endmodule

`default_nettype wire

// File: tb/tb_mult_hilo_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_mult_hilo_ctrl
// Brief    : Directed self-checking bench for mult_hilo_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mult_hilo_ctrl;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  mult_hilo_ctrl_if bus ();

  mult_hilo_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] prod;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [31:0] elo;
    logic [31:0] ehi;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %h want 0", bus.busy); else passed++;
    total++; if (bus.mula !== 16'h0) $display("FAIL reset_mula got %h want 0", bus.mula); else passed++;
    total++; if (bus.mulb !== 16'h0) $display("FAIL reset_mulb got %h want 0", bus.mulb); else passed++;
    total++; if (bus.mulst !== 1'b0) $display("FAIL reset_mulst got %h want 0", bus.mulst); else passed++;
    bus.rdhi = 1'b1; #1;
    total++; if (bus.rddata !== 32'h0) $display("FAIL reset_hi got %h want 0", bus.rddata); else passed++;
    bus.rdhi = 1'b0; bus.rdlo = 1'b1; #1;
    total++; if (bus.rddata !== 32'h0) $display("FAIL reset_lo got %h want 0", bus.rddata); else passed++;
    bus.rdlo = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    bus.wrhi = 1'b1; bus.wrlo = 1'b1; bus.wrdata = 32'hDEAD_BEEF;
    tick();
    bus.wrhi = 1'b0; bus.wrdata = 32'h0000_1234;
    tick();
    bus.wrlo = 1'b0;
    bus.rdhi = 1'b1; bus.rdlo = 1'b1; #1;
    total++; if (bus.rddata !== 32'hDEAD_BEEF) $display("FAIL rd_priority got %h want deadbeef", bus.rddata); else passed++;
    bus.rdhi = 1'b0; #1;
    total++; if (bus.rddata !== 32'h0000_1234) $display("FAIL rd_lo got %h want 00001234", bus.rddata); else passed++;
    total++; if (bus.stall !== 1'b0) $display("FAIL idle_stall got %h want 0", bus.stall); else passed++;
    bus.rdlo = 1'b0; #1;
    total++; if (bus.rddata !== 32'h0) $display("FAIL rd_none got %h want 0", bus.rddata); else passed++;
  endtask

  task automatic test_multiply();
    vec_t v [3];
    v[0] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 32'h0};
    v[1] = '{1'b1, 16'hFFFD, 16'h0007, 32'h0000_0015, 16'h0003, 16'h0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF};
    v[2] = '{1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 16'h8000, 16'h8000, 32'h4000_0000, 32'h0};
    for (int i = 0; i < 3; i++) begin
      bus.mulidle = 1'b1;
      bus.req = 1'b1; bus.sgn = v[i].sgn; bus.opa = v[i].a; bus.opb = v[i].b;
      tick();
      bus.req = 1'b0; bus.opa = 16'h0; bus.opb = 16'h0; #1;
      total++; if (bus.busy !== 1'b1) $display("FAIL mul%0d_busy got %h want 1", i, bus.busy); else passed++;
      total++; if (bus.mula !== v[i].ea) $display("FAIL mul%0d_mula got %h want %h", i, bus.mula, v[i].ea); else passed++;
      total++; if (bus.mulb !== v[i].eb) $display("FAIL mul%0d_mulb got %h want %h", i, bus.mulb, v[i].eb); else passed++;
      total++; if (bus.mulst !== 1'b1) $display("FAIL mul%0d_mulst got %h want 1", i, bus.mulst); else passed++;
      tick();
      total++; if (bus.mulst !== 1'b0) $display("FAIL mul%0d_mulst_off got %h want 0", i, bus.mulst); else passed++;
      bus.mulr = v[i].prod; bus.muldone = 1'b1;
      tick();
      bus.muldone = 1'b0;
      total++; if (bus.busy !== 1'b0) $display("FAIL mul%0d_idle got %h want 0", i, bus.busy); else passed++;
      bus.rdlo = 1'b1; #1;
      total++; if (bus.rddata !== v[i].elo) $display("FAIL mul%0d_lo got %h want %h", i, bus.rddata, v[i].elo); else passed++;
      bus.rdlo = 1'b0; bus.rdhi = 1'b1; #1;
      total++; if (bus.rddata !== v[i].ehi) $display("FAIL mul%0d_hi got %h want %h", i, bus.rddata, v[i].ehi); else passed++;
      bus.rdhi = 1'b0;
    end
  endtask

  task automatic test_req_and_write();
    bus.req = 1'b1; bus.sgn = 1'b0; bus.opa = 16'd2; bus.opb = 16'd3;
    bus.wrhi = 1'b1; bus.wrlo = 1'b1; bus.wrdata = 32'hA5A5_A5A5;
    tick();
    bus.req = 1'b0; bus.wrhi = 1'b0; bus.wrlo = 1'b0;
    bus.rdlo = 1'b1; #1;
    total++; if (bus.rddata !== 32'hA5A5_A5A5) $display("FAIL rw_lo_written got %h want a5a5a5a5", bus.rddata); else passed++;
    total++; if (bus.busy !== 1'b1) $display("FAIL rw_busy got %h want 1", bus.busy); else passed++;
    bus.rdlo = 1'b0;
    tick();
    bus.mulr = 32'd6; bus.muldone = 1'b1;
    tick();
    bus.muldone = 1'b0;
    bus.rdlo = 1'b1; #1;
    total++; if (bus.rddata !== 32'd6) $display("FAIL rw_lo_prod got %h want 6", bus.rddata); else passed++;
    bus.rdlo = 1'b0; bus.rdhi = 1'b1; #1;
    total++; if (bus.rddata !== 32'd0) $display("FAIL rw_hi_prod got %h want 0", bus.rddata); else passed++;
    bus.rdhi = 1'b0;
  endtask

  task automatic test_mulidle_wait();
    bus.mulidle = 1'b0;
    bus.req = 1'b1; bus.sgn = 1'b0; bus.opa = 16'd5; bus.opb = 16'd4;
    tick();
    bus.req = 1'b0;
    bus.mulr = 32'h0000_0BAD; bus.muldone = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (bus.mulst !== 1'b0) $display("FAIL idlewait%0d_mulst got %h want 0", c, bus.mulst); else passed++;
      total++; if (bus.busy !== 1'b1) $display("FAIL idlewait%0d_busy got %h want 1", c, bus.busy); else passed++;
      tick();
    end
    bus.muldone = 1'b0;
    bus.rdlo = 1'b1; #1;
    total++; if (bus.rddata !== 32'd6) $display("FAIL idlewait_done_ignored got %h want 6", bus.rddata); else passed++;
    bus.rdlo = 1'b0;
    bus.mulidle = 1'b1; #1;
    total++; if (bus.mulst !== 1'b1) $display("FAIL idlewait_mulst_on got %h want 1", bus.mulst); else passed++;
    tick();
    total++; if (bus.mulst !== 1'b0) $display("FAIL idlewait_mulst_off got %h want 0", bus.mulst); else passed++;
    bus.mulr = 32'd20; bus.muldone = 1'b1;
    tick();
    bus.muldone = 1'b0;
    bus.rdlo = 1'b1; #1;
    total++; if (bus.rddata !== 32'd20) $display("FAIL idlewait_lo got %h want 20", bus.rddata); else passed++;
    bus.rdlo = 1'b0;
  endtask

  task automatic test_busy_hazards();
    int pulses;
    pulses = 0;
    bus.mulidle = 1'b1;
    bus.req = 1'b1; bus.sgn = 1'b0; bus.opa = 16'd9; bus.opb = 16'd2;
    tick();
    bus.req = 1'b0; #1;
    total++; if (bus.stall !== 1'b0) $display("FAIL hz_stall_quiet got %h want 0", bus.stall); else passed++;
    pulses += int'(bus.mulst);
    tick();
    bus.req = 1'b1; bus.opa = 16'd1; bus.opb = 16'd1;
    bus.rdlo = 1'b1; bus.wrlo = 1'b1; bus.wrdata = 32'h0000_FFFF; #1;
    total++; if (bus.stall !== 1'b1) $display("FAIL hz_stall got %h want 1", bus.stall); else passed++;
    for (int c = 0; c < 3; c++) begin
      pulses += int'(bus.mulst);
      tick();
    end
    total++; if (bus.mula !== 16'd9 || bus.mulb !== 16'd2)
      $display("FAIL hz_operands got %h/%h want 0009/0002", bus.mula, bus.mulb); else passed++;
    bus.req = 1'b0; bus.rdlo = 1'b0; bus.wrlo = 1'b0;
    bus.mulr = 32'd18; bus.muldone = 1'b1;
    tick();
    bus.muldone = 1'b0;
    tick();
    pulses += int'(bus.mulst);
    total++; if (pulses !== 1) $display("FAIL hz_mulst_pulses got %0d want 1", pulses); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL hz_no_relaunch got %h want 0", bus.busy); else passed++;
    bus.rdlo = 1'b1; #1;
    total++; if (bus.rddata !== 32'd18) $display("FAIL hz_lo got %h want 18", bus.rddata); else passed++;
    bus.rdlo = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    bus.wrlo = 1'b1; bus.wrdata = 32'h0000_1234;
    tick();
    bus.wrlo = 1'b0;
    bus.req = 1'b1; bus.sgn = 1'b1; bus.opa = 16'hFFFF; bus.opb = 16'h0001;
    tick();
    bus.req = 1'b0;
    tick();
    total++; if (bus.busy !== 1'b1) $display("FAIL rst_mid_busy got %h want 1", bus.busy); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_mid_idle got %h want 0", bus.busy); else passed++;
    total++; if (bus.mula !== 16'h0) $display("FAIL rst_mid_mula got %h want 0", bus.mula); else passed++;
    bus.rdlo = 1'b1; #1;
    total++; if (bus.rddata !== 32'h0) $display("FAIL rst_mid_lo got %h want 0", bus.rddata); else passed++;
    bus.rdlo = 1'b0; bus.rdhi = 1'b1; #1;
    total++; if (bus.rddata !== 32'h0) $display("FAIL rst_mid_hi got %h want 0", bus.rddata); else passed++;
    bus.rdhi = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.mulr = 32'd77; bus.muldone = 1'b1;
    tick();
    bus.muldone = 1'b0;
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_late_busy got %h want 0", bus.busy); else passed++;
    bus.rdlo = 1'b1; #1;
    total++; if (bus.rddata !== 32'h0) $display("FAIL rst_late_done got %h want 0", bus.rddata); else passed++;
    bus.rdlo = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b1;
    bus.req = 1'b0; bus.sgn = 1'b0; bus.opa = '0; bus.opb = '0;
    bus.rdhi = 1'b0; bus.rdlo = 1'b0; bus.wrhi = 1'b0; bus.wrlo = 1'b0;
    bus.wrdata = '0; bus.mulr = '0; bus.muldone = 1'b0; bus.mulidle = 1'b1;
    #1;
    test_reset();
    test_write_read();
    test_multiply();
    test_req_and_write();
    test_mulidle_wait();
    test_busy_hazards();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/mult_hilo_ctrl.md
MULT_HILO_CTRL -- requirements
Module: mult_hilo_ctrl

Interface
REQ-001 Clk  input  1  single clock; all state updates on rising edge.
REQ-002 Rst  input  1  asynchronous, active-low reset.
REQ-003 Req  input  1  multiply request from pipeline, sampled per cycle.
REQ-004 Sgn  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with Req.
REQ-005 OpA  input  16  multiplicand.
REQ-006 OpB  input  16  multiplier.
REQ-007 RdHi / RdLo  input  1 each  MFHI / MFLO read requests.
REQ-008 WrHi / WrLo  input  1 each  MTHI / MTLO write requests.
REQ-009 WrData  input  32  data for WrHi/WrLo.
REQ-010 RdData  output  32  read data, combinational.
REQ-011 Busy  output  1  high whenever state is not IDLE.
REQ-012 Stall  output  1  pipeline stall request.
REQ-013 MulA, MulB  output  16 each  operands to shift-add multiplier.
REQ-014 MulSt  output  1  one-cycle start pulse to multiplier.
REQ-015 MulR  input  32  multiplier product.
REQ-016 MulDone / MulIdle  input  1 each  multiplier status.

Function
REQ-017 FSM states: IDLE, START, WAIT; encoding local to module.
REQ-018 IDLE + Req: latch |OpA|, |OpB| into MulA/MulB (magnitude only if Sgn=1, else raw), latch Sgn and neg = Sgn & (OpA[15] ^ OpB[15]); go START.
REQ-019 Magnitude of 16'h8000 SHALL be 16'h8000 (unsigned interpretation, no overflow).
REQ-020 START: if MulIdle=1, assert MulSt for exactly one cycle and go WAIT; else remain START with MulSt=0.
REQ-021 WAIT: on MulDone=1, LO <= neg ? (~MulR + 1) : MulR; HI <= (Sgn & LO_new[31]) ? 32'hFFFF_FFFF : 0; go IDLE same edge.
REQ-022 MulA/MulB SHALL hold stable from START entry until IDLE re-entry.
REQ-023 MulDone in IDLE or START SHALL be ignored.
REQ-024 Stall = Busy & (Req | RdHi | RdLo | WrHi | WrLo); Req while Busy SHALL be ignored (no re-latch).
REQ-025 RdData = RdHi ? HI : (RdLo ? LO : 0); RdHi has priority; value reflects registered HI/LO.
REQ-026 WrHi/WrLo honoured only in IDLE; both may write the same cycle; ignored while Busy.
REQ-027 IDLE with Req and WrHi/WrLo in the same cycle: write happens and multiply starts; product later overwrites HI and LO.
REQ-028 Latency: Req edge -> START (1), MulSt issued next cycle if MulIdle, HI/LO valid the cycle after MulDone sampled.

Reset
REQ-029 Rst low: state IDLE, HI=LO=0, MulA=MulB=0, MulSt=0, latched Sgn/neg=0, immediately and asynchronously.
REQ-030 Reset mid-operation abandons the multiply; no HI/LO update; multiplier shares the same Rst.

Structure
REQ-031 FSM state constants and HI/LO width (32) SHALL live in the shared CPU constants package.
REQ-032 One natural sub-module: hilo_regs (HI/LO register pair with write enables and read mux); the multiplier is instantiated by the parent, not inside this block.

Verification
REQ-033 Unsigned: Req, Sgn=0, OpA=16'hFFFF, OpB=16'hFFFF -> LO=32'hFFFE_0001, HI=0, Busy falls after MulDone.
REQ-034 Signed: Sgn=1, OpA=-3 (16'hFFFD), OpB=7 -> MulA=3, MulB=7, LO=32'hFFFF_FFEB, HI=32'hFFFF_FFFF.
REQ-035 Edge: Sgn=1, OpA=OpB=16'h8000 -> MulA=MulB=16'h8000, LO=32'h4000_0000, HI=0.
REQ-036 Busy hazards: RdLo and Req asserted during WAIT -> Stall=1, no relaunch, MulSt pulses once total.
REQ-037 START with MulIdle=0 for 3 cycles -> MulSt stays 0, pulses one cycle after MulIdle rises.
REQ-038 Rst low during WAIT with prior LO=32'h1234 -> LO=0, HI=0, state IDLE, later MulDone ignored.
